// File: rtl/alu_arbiter.sv
// Round-robin front end that shares one combinational alu between two requesters.
// One operation in flight: accept in IDLE, drive the alu for one EXEC cycle, then hold the response.
module alu_arbiter #(
  parameter int WIDTH = 4,
  parameter int SHIFT = 2
) (
  input  logic             clock,
  input  logic             reset,
  input  logic             req0_valid,
  output logic             req0_ready,
  input  logic [WIDTH-1:0] req0_x,
  input  logic [WIDTH-1:0] req0_y,
  input  logic [SHIFT-1:0] req0_shamt,
  input  logic [1:0]       req0_op,
  input  logic             req1_valid,
  output logic             req1_ready,
  input  logic [WIDTH-1:0] req1_x,
  input  logic [WIDTH-1:0] req1_y,
  input  logic [SHIFT-1:0] req1_shamt,
  input  logic [1:0]       req1_op,
  output logic             rsp0_valid,
  input  logic             rsp0_ready,
  output logic             rsp1_valid,
  input  logic             rsp1_ready,
  output logic [WIDTH-1:0] rsp_result,
  output logic             rsp_zero,
  output logic [WIDTH-1:0] alu_x,
  output logic [WIDTH-1:0] alu_y,
  output logic [SHIFT-1:0] alu_shamt,
  output logic [1:0]       alu_operation,
  input  logic [WIDTH-1:0] alu_result,
  input  logic             alu_zero
);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    EXEC = 2'd1,
    RESP = 2'd2
  } state_t;

  state_t           state_q, state_d;
  logic [WIDTH-1:0] x_q, x_d;
  logic [WIDTH-1:0] y_q, y_d;
  logic [SHIFT-1:0] shamt_q, shamt_d;
  logic [1:0]       op_q, op_d;
  logic [WIDTH-1:0] result_q, result_d;
  logic             zero_q, zero_d;
  logic             grant_q, grant_d;
  logic             last_grant_q, last_grant_d;

  logic any_valid;
  logic winner;

  // With both requesting, the one not served last time wins; otherwise the lone requester.
  assign any_valid = req0_valid | req1_valid;
  assign winner    = (req0_valid & req1_valid) ? ~last_grant_q : req1_valid;

  always_comb begin
    state_d      = state_q;
    x_d          = x_q;
    y_d          = y_q;
    shamt_d      = shamt_q;
    op_d         = op_q;
    result_d     = result_q;
    zero_d       = zero_q;
    grant_d      = grant_q;
    last_grant_d = last_grant_q;
    req0_ready   = 1'b0;
    req1_ready   = 1'b0;
    rsp0_valid   = 1'b0;
    rsp1_valid   = 1'b0;

    case (state_q)
      IDLE: begin
        if (any_valid) begin
          // The winner is always valid, so raising its ready completes the handshake.
          req0_ready = ~winner;
          req1_ready = winner;
          x_d        = winner ? req1_x     : req0_x;
          y_d        = winner ? req1_y     : req0_y;
          shamt_d    = winner ? req1_shamt : req0_shamt;
          op_d       = winner ? req1_op    : req0_op;
          grant_d    = winner;
          state_d    = EXEC;
        end
      end
      EXEC: begin
        result_d = alu_result;
        zero_d   = alu_zero;
        state_d  = RESP;
      end
      RESP: begin
        rsp0_valid = ~grant_q;
        rsp1_valid = grant_q;
        if (grant_q ? rsp1_ready : rsp0_ready) begin
          last_grant_d = grant_q;
          state_d      = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      state_q      <= IDLE;
      x_q          <= '0;
      y_q          <= '0;
      shamt_q      <= '0;
      op_q         <= '0;
      result_q     <= '0;
      zero_q       <= 1'b0;
      grant_q      <= 1'b0;
      last_grant_q <= 1'b1;
    end else begin
      state_q      <= state_d;
      x_q          <= x_d;
      y_q          <= y_d;
      shamt_q      <= shamt_d;
      op_q         <= op_d;
      result_q     <= result_d;
      zero_q       <= zero_d;
      grant_q      <= grant_d;
      last_grant_q <= last_grant_d;
    end
  end

  assign alu_x         = x_q;
  assign alu_y         = y_q;
  assign alu_shamt     = shamt_q;
  assign alu_operation = op_q;
  assign rsp_result    = result_q;
  assign rsp_zero      = zero_q;

endmodule

// File: tb/tb_alu_arbiter.sv
// Scoreboard bench for alu_arbiter with an adder alu stub: directed scenarios then random traffic.
module tb_alu_arbiter;

  logic       clock = 1'b0;
  logic       reset;
  logic [1:0] rv;
  logic [1:0] pr;
  logic [3:0] rx [2];
  logic [3:0] ry [2];
  logic [1:0] rs [2];
  logic [1:0] rop [2];
  wire  [1:0] rr;
  wire  [1:0] pv;
  wire  [3:0] rsp_result;
  wire        rsp_zero;
  wire  [3:0] alu_x, alu_y;
  wire  [1:0] alu_shamt, alu_operation;
  logic [3:0] alu_result;
  logic       alu_zero;

  assign alu_result = alu_x + alu_y;
  assign alu_zero   = (alu_result == 4'd0);

  always #5 clock = ~clock;

  alu_arbiter #(.WIDTH(4), .SHIFT(2)) dut (
    .clock(clock), .reset(reset),
    .req0_valid(rv[0]), .req0_ready(rr[0]), .req0_x(rx[0]), .req0_y(ry[0]),
    .req0_shamt(rs[0]), .req0_op(rop[0]),
    .req1_valid(rv[1]), .req1_ready(rr[1]), .req1_x(rx[1]), .req1_y(ry[1]),
    .req1_shamt(rs[1]), .req1_op(rop[1]),
    .rsp0_valid(pv[0]), .rsp0_ready(pr[0]), .rsp1_valid(pv[1]), .rsp1_ready(pr[1]),
    .rsp_result(rsp_result), .rsp_zero(rsp_zero),
    .alu_x(alu_x), .alu_y(alu_y), .alu_shamt(alu_shamt), .alu_operation(alu_operation),
    .alu_result(alu_result), .alu_zero(alu_zero)
  );

  typedef struct {
    int         req;
    logic [3:0] res;
    logic       z;
  } exp_t;

  exp_t sb[$];
  int   grant_log[$];
  int   checks = 0;
  int   failures = 0;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %0d expected %0d at %0t", nm, act, exp, $time);
    end
  endtask

  // Reference model: one job outstanding, round-robin among valid requesters.
  int         cyc = 0;
  bit         busy = 0;
  int         breq = 0;
  int         acc = 0;
  int         last = 1;
  logic [3:0] sx, sy;
  logic [1:0] ss, so;

  always @(negedge clock) begin : monitor
    int         win;
    logic [1:0] exp_rr, exp_pv;
    cyc++;
    if (!reset) begin
      busy = 0;
      last = 1;
      sb.delete();
    end else begin
      win    = (rv == 2'b11) ? 1 - last : (rv[1] ? 1 : 0);
      exp_rr = (busy || rv == 2'b00) ? 2'b00 : 2'(1 << win);
      chk("req_ready", 32'(rr), 32'(exp_rr));
      exp_pv = (busy && cyc >= acc + 2) ? 2'(1 << breq) : 2'b00;
      chk("rsp_valid", 32'(pv), 32'(exp_pv));
      if (busy && cyc == acc + 1) begin
        chk("alu_x", 32'(alu_x), 32'(sx));
        chk("alu_y", 32'(alu_y), 32'(sy));
        chk("alu_shamt", 32'(alu_shamt), 32'(ss));
        chk("alu_operation", 32'(alu_operation), 32'(so));
      end
      if (pv != 2'b00) begin
        if (sb.size() == 0) begin
          checks++;
          failures++;
          $display("FAIL sb_empty: got rsp_valid=%0d required no response", pv);
        end else begin
          chk("rsp_req", 32'(pv), 32'(1 << sb[0].req));
          chk("rsp_result", 32'(rsp_result), 32'(sb[0].res));
          chk("rsp_zero", 32'(rsp_zero), 32'(sb[0].z));
          if ((pv & pr) != 2'b00) void'(sb.pop_front());
        end
      end
      if (busy && exp_pv != 2'b00 && pr[breq]) begin
        busy = 0;
        last = breq;
      end else if (!busy && rv != 2'b00) begin
        busy = 1;
        breq = win;
        acc  = cyc;
        sx   = rx[win];
        sy   = ry[win];
        ss   = rs[win];
        so   = rop[win];
        grant_log.push_back(rr == 2'b10 ? 1 : (rr == 2'b01 ? 0 : -1));
      end
    end
  end

  task automatic issue(input int n, input logic [3:0] x, input logic [3:0] y,
                       input logic [1:0] s, input logic [1:0] o);
    exp_t e;
    bit   got = 0;
    rv[n] = 1'b1; rx[n] = x; ry[n] = y; rs[n] = s; rop[n] = o;
    for (int i = 0; i < 100; i++) begin
      @(negedge clock);
      if (rr[n]) begin
        e.req = n;
        e.res = 4'(x + y);
        e.z   = (e.res == 4'd0);
        sb.push_back(e);
        got = 1;
        break;
      end
    end
    if (!got) begin
      checks++;
      failures++;
      $display("FAIL issue_timeout: req%0d ready never seen, required within 100 cycles", n);
    end
    @(posedge clock);
    #1;
    rv[n] = 1'b0;
    rx[n] = 4'($urandom); ry[n] = 4'($urandom);
  endtask

  task automatic wait_pv(input int n, output int lat);
    lat = -1;
    for (int i = 0; i < 20; i++) begin
      @(negedge clock);
      if (pv[n]) begin
        lat = i + 1;
        break;
      end
    end
    if (lat < 0) begin
      checks++;
      failures++;
      $display("FAIL rsp_timeout: rsp%0d_valid never seen, required within 20 cycles", n);
    end
  endtask

  task automatic wait_drain(input int budget);
    bit done = 0;
    for (int i = 0; i < budget; i++) begin
      @(negedge clock);
      if (!busy && sb.size() == 0) begin
        done = 1;
        break;
      end
    end
    if (!done) begin
      checks++;
      failures++;
      $display("FAIL drain_timeout: %0d responses outstanding, required 0", sb.size());
    end
    @(posedge clock);
    #1;
  endtask

  task automatic do_reset();
    @(posedge clock); #1 reset = 1'b0;
    @(posedge clock); #1 reset = 1'b1;
  endtask

  initial begin
    int lat;
    int order [4];
    bit d0, d1;
    reset = 1'b0;
    rv = 2'b00;
    pr = 2'b11;
    for (int i = 0; i < 2; i++) begin
      rx[i] = '0; ry[i] = '0; rs[i] = '0; rop[i] = '0;
    end
    repeat (3) @(posedge clock);
    #1;
    chk("reset_ready", 32'(rr), 32'd0);
    chk("reset_rsp_valid", 32'(pv), 32'd0);
    chk("reset_alu_x", 32'(alu_x), 32'd0);
    chk("reset_alu_y", 32'(alu_y), 32'd0);
    chk("reset_alu_ctl", 32'({alu_shamt, alu_operation}), 32'd0);
    chk("reset_rsp_data", 32'({rsp_result, rsp_zero}), 32'd0);
    reset = 1'b1;
    repeat (2) @(posedge clock);
    #1;
    chk("idle_ready", 32'(rr), 32'd0);

    // basic transaction and latency
    issue(0, 4'd3, 4'd4, 2'd1, 2'd2);
    wait_pv(0, lat);
    chk("t1_latency", 32'(lat), 32'd2);
    chk("t1_result", 32'(rsp_result), 32'd7);
    chk("t1_zero", 32'(rsp_zero), 32'd0);
    wait_drain(20);

    // wrap-around to zero
    issue(1, 4'd9, 4'd7, 2'd3, 2'd1);
    wait_pv(1, lat);
    chk("t2_result", 32'(rsp_result), 32'd0);
    chk("t2_zero", 32'(rsp_zero), 32'd1);
    wait_drain(20);

    // contention from reset alternates grants
    do_reset();
    grant_log.delete();
    fork
      begin issue(0, 4'd1, 4'd2, 2'd0, 2'd0); issue(0, 4'd5, 4'd5, 2'd1, 2'd1); end
      begin issue(1, 4'd8, 4'd8, 2'd2, 2'd2); issue(1, 4'd15, 4'd2, 2'd3, 2'd3); end
    join
    wait_drain(40);
    order = '{0, 1, 0, 1};
    chk("t3_grant_count", 32'(grant_log.size()), 32'd4);
    for (int i = 0; i < 4; i++)
      if (i < grant_log.size()) chk("t3_grant_order", 32'(grant_log[i]), 32'(order[i]));

    // response back-pressure with a competing request arriving during RESP
    pr[0] = 1'b0;
    fork
      issue(0, 4'd6, 4'd5, 2'd2, 2'd3);
      begin repeat (3) begin @(posedge clock); #1; end issue(1, 4'd2, 4'd2, 2'd1, 2'd0); end
      begin repeat (7) begin @(posedge clock); #1; end pr[0] = 1'b1; end
    join
    wait_drain(40);

    // reset during EXEC drops the operation
    issue(0, 4'd5, 4'd6, 2'd3, 2'd1);
    #1 reset = 1'b0;
    #1;
    chk("t5_ready", 32'(rr), 32'd0);
    chk("t5_rsp_valid", 32'(pv), 32'd0);
    chk("t5_alu_x", 32'(alu_x), 32'd0);
    chk("t5_alu_y", 32'(alu_y), 32'd0);
    @(posedge clock);
    #1 reset = 1'b1;
    repeat (4) begin
      @(negedge clock);
      chk("t5_no_rsp", 32'(pv), 32'd0);
    end
    @(posedge clock);
    #1;
    issue(1, 4'd2, 4'd3, 2'd0, 2'd2);
    wait_pv(1, lat);
    chk("t5_next_result", 32'(rsp_result), 32'd5);
    wait_drain(20);

    // random traffic with random response back-pressure
    d0 = 0;
    d1 = 0;
    fork
      begin
        for (int i = 0; i < 25; i++) begin
          repeat ($urandom_range(0, 3)) begin @(posedge clock); #1; end
          issue(0, 4'($urandom), 4'($urandom), 2'($urandom), 2'($urandom));
        end
        d0 = 1;
      end
      begin
        for (int i = 0; i < 25; i++) begin
          repeat ($urandom_range(0, 3)) begin @(posedge clock); #1; end
          issue(1, 4'($urandom), 4'($urandom), 2'($urandom), 2'($urandom));
        end
        d1 = 1;
      end
      begin
        while (!(d0 && d1)) begin
          @(posedge clock);
          #1 pr = 2'($urandom_range(0, 3));
        end
      end
    join
    pr = 2'b11;
    wait_drain(100);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
